lfsr_checker: RTL and testbench

Serial LFSR sequence checker: the receive-side counterpart of the `lfsr` generator. It self-synchronises to an incoming Fibonacci LFSR bit stream using the same polynomial. Once locked, it free-runs a local copy of the sequence, flags every mismatching bit and counts the errors. It sits at the far end of a serial link or loopback path, fed with the generator's `dout`.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_feedback.sv | 19 +
 rtl/lfsr_checker.sv | 150 +++++++++++++++
 tb/tb_lfsr_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_pkg : FSM state encoding and default LFSR constants shared by lfsr
//            and lfsr_checker.  Rev 1.0
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_DEFAULT_WIDTH = 11;
  localparam logic [LFSR_DEFAULT_WIDTH-1:0] LFSR_DEFAULT_POLY = 11'b10100000000;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEED   = 2'd0;
  localparam state_t ST_VERIFY = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/lfsr_feedback.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_feedback : XOR-reduce of state & polynomial (Fibonacci tap function).
//                 Rev 1.0
// ---------------------------------------------------------------------------
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int                  WIDTH      = LFSR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]    POLYNOMIAL = LFSR_DEFAULT_POLY
) (
  input  logic [WIDTH-1:0] state,
  output logic             feedback
);

  assign feedback = ^(state & POLYNOMIAL);

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_checker : self-synchronising LFSR sequence checker with error counter.
//                Counter built only when LFSR_CHECKER_ERR_CNT_EN is defined.
//                Rev 1.0
// ---------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                     LFSR_WIDTH      = LFSR_DEFAULT_WIDTH,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_POLYNOMIAL = LFSR_DEFAULT_POLY,
  parameter int                     LOCK_COUNT      = 16,
  parameter int                     LOSS_WINDOW     = 64,
  parameter int                     LOSS_COUNT      = 8,
  parameter int                     ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     din,
  input  logic                     clr_err,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int FILL_W = $clog2(LFSR_WIDTH) + 1;
  localparam int RUN_W  = $clog2(LOCK_COUNT) + 1;
  localparam int WIN_W  = $clog2(LOSS_WINDOW) + 1;
  localparam int WERR_W = $clog2(LOSS_COUNT) + 1;

  state_t                state, state_nx;
  logic [LFSR_WIDTH-1:0] r, r_nx;
  logic [FILL_W-1:0]     fill, fill_nx;
  logic [RUN_W-1:0]      run, run_nx;
  logic [WIN_W-1:0]      win, win_nx;
  logic [WERR_W-1:0]     werr, werr_nx;
  logic                  pred;
  logic                  bad;

  lfsr_feedback #(
    .WIDTH      (LFSR_WIDTH),
    .POLYNOMIAL (LFSR_POLYNOMIAL)
  ) u_feedback (
    .state    (r),
    .feedback (pred)
  );

  always_comb begin
    state_nx = state;
    r_nx     = r;
    fill_nx  = fill;
    run_nx   = run;
    win_nx   = win;
    werr_nx  = werr;
    bad      = 1'b0;
    if (en) begin
      case (state)
        ST_SEED: begin
          r_nx = {r[LFSR_WIDTH-2:0], din};
          if (fill == FILL_W'(LFSR_WIDTH - 1)) begin
            state_nx = ST_VERIFY;
            fill_nx  = '0;
            run_nx   = '0;
          end else begin
            fill_nx = fill + 1'b1;
          end
        end
        ST_VERIFY: begin
          r_nx = {r[LFSR_WIDTH-2:0], din};
          // An all-zero register trivially predicts zeros; never count it.
          if ((r == '0) || (din != pred)) begin
            run_nx = '0;
          end else if (run == RUN_W'(LOCK_COUNT - 1)) begin
            state_nx = ST_LOCKED;
            run_nx   = '0;
            win_nx   = '0;
            werr_nx  = '0;
          end else begin
            run_nx = run + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Free-running: a corrupted input bit never enters the register.
          r_nx = {r[LFSR_WIDTH-2:0], pred};
          bad  = (din != pred);
          if (bad && (werr == WERR_W'(LOSS_COUNT - 1))) begin
            state_nx = ST_SEED;
            fill_nx  = '0;
            run_nx   = '0;
            win_nx   = '0;
            werr_nx  = '0;
          end else if (win == WIN_W'(LOSS_WINDOW - 1)) begin
            win_nx  = '0;
            werr_nx = '0;
          end else begin
            win_nx  = win + 1'b1;
            werr_nx = werr + WERR_W'(bad);
          end
        end
        default: state_nx = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_SEED;
      r      <= '0;
      fill   <= '0;
      run    <= '0;
      win    <= '0;
      werr   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      r      <= r_nx;
      fill   <= fill_nx;
      run    <= run_nx;
      win    <= win_nx;
      werr   <= werr_nx;
      locked <= (state_nx == ST_LOCKED);
      err    <= bad;
    end
  end

`ifdef LFSR_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr_err) begin
      cnt <= '0;
    end else if (bad && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign err_cnt = cnt;
`else
  logic unused_clr_err;

  assign unused_clr_err = clr_err;
  assign err_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lfsr_checker : directed self-checking bench for lfsr_checker.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam logic [10:0] POLY = 11'b10100000000;
  localparam logic [10:0] SEED = 11'b11011011011;
`ifdef LFSR_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        din = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, err, locked3, err3;
  logic [15:0] err_cnt;
  logic [2:0]  err_cnt3;
  logic [10:0] g = SEED;
  int          err_seen;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (din),
    .clr_err (clr_err),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  lfsr_checker #(.ERR_CNT_WIDTH(3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (din),
    .clr_err (clr_err),
    .locked  (locked3),
    .err     (err3),
    .err_cnt (err_cnt3)
  );

  function automatic int unsigned exp_cnt(input int unsigned n, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    if (!CNT_EN) return 0;
    return (n > mx) ? mx : n;
  endfunction

  // One valid bit from the reference generator, optionally inverted on the wire.
  task automatic step(input bit flip, input bit clr);
    logic nb;
    nb      = ^(g & POLY);
    din     = nb ^ flip;
    en      = 1'b1;
    clr_err = clr;
    @(posedge clk);
    #1;
    g       = {g[9:0], nb};
    en      = 1'b0;
    clr_err = 1'b0;
    if (err === 1'b1) err_seen++;
  endtask

  task automatic idle();
    en  = 1'b0;
    din = ~din;
    @(posedge clk);
    #1;
    if (err === 1'b1) err_seen++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    g        = SEED;
    err_seen = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = i[0];
      @(posedge clk);
      #1;
      tests++;
      if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0 || err_cnt3 !== 3'd0) begin
        fails++;
        $display("FAIL reset cyc%0d: locked=%b err=%b err_cnt=%0d err_cnt3=%0d, required all 0",
                 i, locked, err, err_cnt, err_cnt3);
      end
    end
    reset_n  = 1'b1;
    en       = 1'b0;
    g        = SEED;
    err_seen = 0;
  endtask

  task automatic test_clean_lock();
    for (int i = 1; i <= 500; i++) begin
      step(1'b0, 1'b0);
      if (i == 26) begin
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL clean_lock_early: locked=%b after 26 bits, required 0", locked);
        end
      end
      if (i == 27) begin
        tests++;
        if (locked !== 1'b1) begin
          fails++;
          $display("FAIL clean_lock_at27: locked=%b after 27 bits, required 1", locked);
        end
      end
      if (i % 5 == 0) idle();
    end
    tests++;
    if (err_seen !== 0 || err_cnt !== 16'd0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL clean_500: err pulses=%0d err_cnt=%0d locked=%b, required 0/0/1",
               err_seen, err_cnt, locked);
    end
  endtask

  task automatic test_single_error();
    step(1'b1, 1'b0);
    tests++;
    if (err !== 1'b1 || locked !== 1'b1 || err_cnt !== 16'(exp_cnt(1, 16))) begin
      fails++;
      $display("FAIL single_err: err=%b locked=%b err_cnt=%0d, required 1/1/%0d",
               err, locked, err_cnt, exp_cnt(1, 16));
    end
    step(1'b0, 1'b0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL single_err_pulse_width: err=%b one cycle later, required 0", err);
    end
    err_seen = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0);
    tests++;
    if (err_seen !== 0 || err_cnt !== 16'(exp_cnt(1, 16)) || locked !== 1'b1) begin
      fails++;
      $display("FAIL single_err_after: err pulses=%0d err_cnt=%0d locked=%b, required 0/%0d/1",
               err_seen, err_cnt, locked, exp_cnt(1, 16));
    end
  endtask

  task automatic test_all_zero();
    int lk;
    do_reset();
    lk = 0;
    for (int i = 0; i < 200; i++) begin
      din = 1'b0;
      en  = 1'b1;
      @(posedge clk);
      #1;
      if (locked !== 1'b0) lk++;
    end
    en = 1'b0;
    tests++;
    if (lk !== 0) begin
      fails++;
      $display("FAIL all_zero: locked high on %0d cycles, required 0", lk);
    end
  endtask

  task automatic test_loss_relock();
    do_reset();
    for (int i = 0; i < 27; i++) step(1'b0, 1'b0);
    tests++;
    if (locked !== 1'b1) begin
      fails++;
      $display("FAIL loss_prelock: locked=%b, required 1", locked);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      if (k == 7) begin
        tests++;
        if (locked !== 1'b1) begin
          fails++;
          $display("FAIL loss_7th: locked=%b after 7 errors, required 1", locked);
        end
      end
      if (k < 8) step(1'b0, 1'b0);
    end
    tests++;
    if (locked !== 1'b0 || err !== 1'b1 || err_cnt !== 16'(exp_cnt(8, 16))
        || err_cnt3 !== 3'(exp_cnt(8, 3)) || locked3 !== 1'b0) begin
      fails++;
      $display("FAIL loss_8th: locked=%b err=%b err_cnt=%0d err_cnt3=%0d locked3=%b, required 0/1/%0d/%0d/0",
               locked, err, err_cnt, err_cnt3, locked3, exp_cnt(8, 16), exp_cnt(8, 3));
    end
    for (int i = 1; i <= 27; i++) begin
      step(1'b0, 1'b0);
      if (i == 26) begin
        tests++;
        if (locked !== 1'b0) begin
          fails++;
          $display("FAIL relock_early: locked=%b after 26 bits, required 0", locked);
        end
      end
    end
    tests++;
    if (locked !== 1'b1 || err_cnt !== 16'(exp_cnt(8, 16))) begin
      fails++;
      $display("FAIL relock: locked=%b err_cnt=%0d, required 1/%0d",
               locked, err_cnt, exp_cnt(8, 16));
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int i = 0; i < 27; i++) step(1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    end
    tests++;
    if (err_cnt !== 16'(exp_cnt(10, 16)) || err_cnt3 !== 3'(exp_cnt(10, 3))
        || locked !== 1'b1 || locked3 !== 1'b1) begin
      fails++;
      $display("FAIL saturate: err_cnt=%0d err_cnt3=%0d locked=%b locked3=%b, required %0d/%0d/1/1",
               err_cnt, err_cnt3, locked, locked3, exp_cnt(10, 16), exp_cnt(10, 3));
    end
    step(1'b1, 1'b1);
    tests++;
    if (err_cnt !== 16'd0 || err_cnt3 !== 3'd0 || err3 !== 1'b1) begin
      fails++;
      $display("FAIL clr_with_err: err_cnt=%0d err_cnt3=%0d err3=%b, required 0/0/1",
               err_cnt, err_cnt3, err3);
    end
    step(1'b1, 1'b0);
    tests++;
    if (err_cnt3 !== 3'(exp_cnt(1, 3))) begin
      fails++;
      $display("FAIL count_after_clr: err_cnt3=%0d, required %0d", err_cnt3, exp_cnt(1, 3));
    end
    en      = 1'b0;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    tests++;
    if (err_cnt3 !== 3'd0 || err_cnt !== 16'd0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL clr_no_en: err_cnt=%0d err_cnt3=%0d locked=%b, required 0/0/1",
               err_cnt, err_cnt3, locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_all_zero();
    test_loss_relock();
    test_saturation_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
